// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and command handshake between the UART receiver, the
// command parser and the game logic that consumes commands.
interface uart_cmd_parser_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd;
   logic [7:0] arg;
   logic       err_chk;
   logic       err_timeout;
   logic       err_overflow;
   logic [7:0] chk_err_cnt;

   // Environment side: feeds bytes, accepts commands.
   modport master (
      output rx_data, rx_valid, cmd_ready,
      input  cmd_valid, cmd, arg, err_chk, err_timeout, err_overflow, chk_err_cnt
   );

   // Parser side.
   modport slave (
      input  rx_data, rx_valid, cmd_ready,
      output cmd_valid, cmd, arg, err_chk, err_timeout, err_overflow, chk_err_cnt
   );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles SYNC/CMD/ARG/CHK frames from the UART byte stream, verifies the
// XOR checksum and offers good commands to game logic over valid/ready.
module uart_cmd_parser #(
   parameter int unsigned CLK_FREQ   = 65_000_000,
   parameter int unsigned TIMEOUT_US = 2000,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input logic              clk,
   input logic              rst_n,
   uart_cmd_parser_if.slave bus
);
   localparam logic [31:0] TIMEOUT_CYCLES = 32'((CLK_FREQ / 32'd1_000_000) * TIMEOUT_US);
   localparam logic [31:0] TIMEOUT_LAST   = TIMEOUT_CYCLES - 32'd1;

   typedef enum logic [1:0] {S_SYNC, S_CMD, S_ARG, S_CHK} state_t;

   state_t      state_r;
   logic [31:0] timer_r;
   logic [7:0]  cmd_tmp_r;
   logic [7:0]  arg_tmp_r;
   logic        cmd_valid_r;
   logic [7:0]  cmd_r;
   logic [7:0]  arg_r;
   logic        err_chk_r;
   logic        err_timeout_r;
   logic        err_overflow_r;
   logic [7:0]  chk_err_cnt_r;

   logic        expired_s;
   logic        slot_free_s;

   function automatic logic [7:0] frame_chk(input logic [7:0] c, input logic [7:0] a);
      return c ^ a;
   endfunction

   // A strobe in the expiry cycle wins, so expiry is only acted on without rx_valid.
   assign expired_s   = (timer_r == TIMEOUT_LAST) && !bus.rx_valid;
   assign slot_free_s = !cmd_valid_r || bus.cmd_ready;

   // Frame FSM, inter-byte timer, command slot and error reporting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= S_SYNC;
         timer_r        <= 32'd0;
         cmd_tmp_r      <= 8'd0;
         arg_tmp_r      <= 8'd0;
         cmd_valid_r    <= 1'b0;
         cmd_r          <= 8'd0;
         arg_r          <= 8'd0;
         err_chk_r      <= 1'b0;
         err_timeout_r  <= 1'b0;
         err_overflow_r <= 1'b0;
         chk_err_cnt_r  <= 8'd0;
      end else begin
         err_chk_r      <= 1'b0;
         err_timeout_r  <= 1'b0;
         err_overflow_r <= 1'b0;

         if (cmd_valid_r && bus.cmd_ready) begin
            cmd_valid_r <= 1'b0;
         end

         if ((state_r == S_SYNC) || bus.rx_valid) begin
            timer_r <= 32'd0;
         end else begin
            timer_r <= timer_r + 32'd1;
         end

         case (state_r)
            S_SYNC: begin
               if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                  state_r <= S_CMD;
               end
            end
            S_CMD: begin
               if (bus.rx_valid) begin
                  cmd_tmp_r <= bus.rx_data;
                  state_r   <= S_ARG;
               end else if (expired_s) begin
                  state_r       <= S_SYNC;
                  err_timeout_r <= 1'b1;
               end
            end
            S_ARG: begin
               if (bus.rx_valid) begin
                  arg_tmp_r <= bus.rx_data;
                  state_r   <= S_CHK;
               end else if (expired_s) begin
                  state_r       <= S_SYNC;
                  err_timeout_r <= 1'b1;
               end
            end
            S_CHK: begin
               if (bus.rx_valid) begin
                  state_r <= S_SYNC;
                  if (bus.rx_data != frame_chk(cmd_tmp_r, arg_tmp_r)) begin
                     err_chk_r <= 1'b1;
                     if (chk_err_cnt_r != 8'hFF) begin
                        chk_err_cnt_r <= chk_err_cnt_r + 8'd1;
                     end
                  end else if (slot_free_s) begin
                     // Overrides the acceptance clear above when a new frame lands.
                     cmd_r       <= cmd_tmp_r;
                     arg_r       <= arg_tmp_r;
                     cmd_valid_r <= 1'b1;
                  end else begin
                     err_overflow_r <= 1'b1;
                  end
               end else if (expired_s) begin
                  state_r       <= S_SYNC;
                  err_timeout_r <= 1'b1;
               end
            end
            default: begin
               state_r <= S_SYNC;
            end
         endcase
      end
   end

   assign bus.cmd_valid    = cmd_valid_r;
   assign bus.cmd          = cmd_r;
   assign bus.arg          = arg_r;
   assign bus.err_chk      = err_chk_r;
   assign bus.err_timeout  = err_timeout_r;
   assign bus.err_overflow = err_overflow_r;
   assign bus.chk_err_cnt  = chk_err_cnt_r;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized
// traffic compared each cycle against a frame-level reference model.
module tb_uart_cmd_parser;
   localparam int unsigned CLK_FREQ   = 10_000_000;
   localparam int unsigned TIMEOUT_US = 1;
   localparam logic [7:0]  SYNC       = 8'hA5;
   localparam int          T          = (CLK_FREQ / 1_000_000) * TIMEOUT_US;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;

   uart_cmd_parser_if bus();

   uart_cmd_parser #(
      .CLK_FREQ  (CLK_FREQ),
      .TIMEOUT_US(TIMEOUT_US),
      .SYNC_BYTE (SYNC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: bytes of the frame in progress and the command slot.
   logic [7:0] m_buf[$];
   int         m_last;
   logic       m_valid;
   logic [7:0] m_cmd, m_arg, m_cnt;
   logic       m_echk, m_eto, m_eov;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] dut_vec();
      return {4'd0, bus.cmd_valid, bus.cmd, bus.arg,
              bus.err_chk, bus.err_timeout, bus.err_overflow, bus.chk_err_cnt};
   endfunction

   function automatic logic [31:0] exp_vec();
      return {4'd0, m_valid, m_cmd, m_arg, m_echk, m_eto, m_eov, m_cnt};
   endfunction

   task automatic model_reset();
      m_buf.delete();
      m_last  = 0;
      m_valid = 1'b0;
      m_cmd   = 8'd0;
      m_arg   = 8'd0;
      m_cnt   = 8'd0;
      m_echk  = 1'b0;
      m_eto   = 1'b0;
      m_eov   = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic rdy);
      logic       free;
      logic [7:0] c, a;
      free   = !m_valid || rdy;
      m_echk = 1'b0;
      m_eto  = 1'b0;
      m_eov  = 1'b0;
      if (m_valid && rdy) m_valid = 1'b0;
      if (v) begin
         if (m_buf.size() != 0 || d == SYNC) begin
            m_buf.push_back(d);
            m_last = cyc;
         end
         if (m_buf.size() == 4) begin
            c = m_buf[1];
            a = m_buf[2];
            if (d != (c ^ a)) begin
               m_echk = 1'b1;
               if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end else if (free) begin
               m_valid = 1'b1;
               m_cmd   = c;
               m_arg   = a;
            end else begin
               m_eov = 1'b1;
            end
            m_buf.delete();
         end
      end else if (m_buf.size() != 0 && (cyc - m_last) == T) begin
         m_eto = 1'b1;
         m_buf.delete();
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic rdy);
      @(negedge clk);
      bus.rx_valid  = v;
      bus.rx_data   = d;
      bus.cmd_ready = rdy;
      model_step(v, d, rdy);
      @(posedge clk);
      #1;
      check_eq("cycle", dut_vec(), exp_vec());
      cyc++;
   endtask

   task automatic send(input logic [7:0] d, input logic rdy);
      step(1'b1, d, rdy);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy);
   endtask

   task automatic check_cmd(input string tag, input logic v, input logic [7:0] c, input logic [7:0] a);
      check_eq(tag, {15'd0, bus.cmd_valid, bus.cmd, bus.arg}, {15'd0, v, c, a});
   endtask

   initial begin
      logic [7:0] c, a, k;
      int         kind, gap;
      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.cmd_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("reset", dut_vec(), 32'd0);
      rst_n = 1'b1;
      idle(2, 1'b1);

      // Basic delivery and release.
      send(8'hA5, 1'b1); send(8'h01, 1'b1); send(8'h10, 1'b1); send(8'h11, 1'b1);
      check_cmd("t1_deliver", 1'b1, 8'h01, 8'h10);
      idle(1, 1'b1);
      check_eq("t1_release", {31'd0, bus.cmd_valid}, 32'd0);

      // Bad checksum then good frame.
      send(8'hA5, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'hFF, 1'b1);
      check_eq("t2_errchk", {23'd0, bus.err_chk, bus.chk_err_cnt}, {23'd0, 1'b1, 8'd1});
      check_eq("t2_novalid", {31'd0, bus.cmd_valid}, 32'd0);
      send(8'hA5, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h01, 1'b1);
      check_cmd("t2_deliver", 1'b1, 8'h02, 8'h03);
      idle(2, 1'b1);

      // Leading junk.
      send(8'h00, 1'b1); send(8'h37, 1'b1);
      send(8'hA5, 1'b1); send(8'h04, 1'b1); send(8'h05, 1'b1); send(8'h01, 1'b1);
      check_cmd("t3_deliver", 1'b1, 8'h04, 8'h05);
      idle(2, 1'b1);

      // Timeout, then a byte on the exact expiry cycle.
      send(8'hA5, 1'b1); send(8'h06, 1'b1);
      idle(T, 1'b1);
      check_eq("t4_timeout", {31'd0, bus.err_timeout}, 32'd1);
      send(8'hA5, 1'b1); send(8'h07, 1'b1); send(8'h08, 1'b1); send(8'h0F, 1'b1);
      check_cmd("t4_deliver", 1'b1, 8'h07, 8'h08);
      idle(2, 1'b1);
      send(8'hA5, 1'b1); idle(T - 1, 1'b1); send(8'h0A, 1'b1);
      check_eq("t4_edge_noto", {31'd0, bus.err_timeout}, 32'd0);
      idle(T - 1, 1'b1); send(8'h0B, 1'b1); idle(T - 1, 1'b1); send(8'h01, 1'b1);
      check_cmd("t4_edge_deliver", 1'b1, 8'h0A, 8'h0B);
      idle(2, 1'b1);

      // Overflow and same-cycle reload.
      send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
      check_cmd("t5_first", 1'b1, 8'h01, 8'h02);
      send(8'hA5, 1'b0); send(8'h09, 1'b0); send(8'h09, 1'b0); send(8'h00, 1'b0);
      check_eq("t5_overflow", {31'd0, bus.err_overflow}, 32'd1);
      check_cmd("t5_hold", 1'b1, 8'h01, 8'h02);
      send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0); send(8'h07, 1'b1);
      check_cmd("t5_reload", 1'b1, 8'h03, 8'h04);
      idle(2, 1'b1);

      // Counter saturation, then asynchronous reset mid-frame.
      for (int i = 0; i < 256; i++) begin
         send(8'hA5, 1'b1); send(8'h01, 1'b1); send(8'h01, 1'b1); send(8'hFF, 1'b1);
      end
      check_eq("t6_saturate", {24'd0, bus.chk_err_cnt}, 32'd255);
      send(8'hA5, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1);
      send(8'hA5, 1'b0); send(8'h01, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_rst", dut_vec(), 32'd0);
      model_reset();
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(8'h10, 1'b1); send(8'h11, 1'b1);
      check_eq("t6_no_resume", dut_vec(), 32'd0);
      send(8'hA5, 1'b1); send(8'h01, 1'b1); send(8'h10, 1'b1); send(8'h11, 1'b1);
      check_cmd("t6_deliver", 1'b1, 8'h01, 8'h10);
      idle(2, 1'b1);

      // Randomized frames: good, bad, stalled, junk; random gaps and ready.
      for (int i = 0; i < 400; i++) begin
         kind = int'($urandom_range(0, 9));
         if (kind == 0) begin
            send(8'($urandom), 1'($urandom_range(0, 1)));
         end
         c = 8'($urandom);
         a = 8'($urandom);
         k = (kind == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
         for (int b = 0; b < 4; b++) begin
            gap = (kind == 2 && b == 2) ? int'($urandom_range(T - 1, T + 2))
                                        : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) step(1'b0, 8'h00, ($urandom_range(0, 3) != 0));
            case (b)
               0:       send(SYNC, ($urandom_range(0, 3) != 0));
               1:       send(c, ($urandom_range(0, 3) != 0));
               2:       send(a, ($urandom_range(0, 3) != 0));
               default: send(c ^ a ^ k, ($urandom_range(0, 3) != 0));
            endcase
         end
      end
      idle(T + 2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Downstream consumer of the UART receiver's byte stream (8-bit data plus 1-cycle valid strobe). Assembles 4-byte command frames: SYNC, CMD, ARG, CHK. Verifies the checksum and presents each good command to game logic (flap, start, pause, etc.) through a valid/ready handshake. Bad, stalled or overflowing frames are dropped and flagged.

Parameters:
CLK_FREQ, 65_000_000, system clock in Hz
TIMEOUT_US, 2000, maximum gap between bytes of one frame, in microseconds
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte; valid only when rx_valid=1
rx_valid  in  1  single-cycle strobe, one per received byte
cmd_valid  out  1  command available; held until accepted
cmd_ready  in  1  consumer accepts the command when cmd_valid & cmd_ready
cmd  out  8  command code
arg  out  8  command argument
err_chk  out  1  1-cycle pulse: checksum mismatch
err_timeout  out  1  1-cycle pulse: inter-byte timeout
err_overflow  out  1  1-cycle pulse: good frame dropped because previous command not yet accepted
chk_err_cnt  out  8  saturating count of checksum errors

Behaviour:
- Reset (async assert, sync use after release): state=S_SYNC, timer=0. cmd_valid=0, cmd=0, arg=0, all err_* = 0, chk_err_cnt=0.
- TIMEOUT_CYCLES = (CLK_FREQ/1_000_000)*TIMEOUT_US. Timer is 32 bits.
- States:
  - S_SYNC: on rx_valid with rx_data==SYNC_BYTE go to S_CMD. Any other byte is discarded silently.
  - S_CMD: on rx_valid latch cmd_tmp, go to S_ARG.
  - S_ARG: on rx_valid latch arg_tmp, go to S_CHK.
  - S_CHK: on rx_valid compare rx_data with (cmd_tmp ^ arg_tmp), then go to S_SYNC.
  - In S_CMD/S_ARG/S_CHK a SYNC_BYTE value is ordinary data. There is no mid-frame resync.
- Checksum rule: CHK = CMD XOR ARG, 8 bits.
- Mismatch: pulse err_chk for 1 cycle the cycle after the CHK byte. chk_err_cnt increments by 1 and saturates at 255 (no wrap). Outputs are unchanged.
- Match, output slot free (cmd_valid=0, or cmd_valid & cmd_ready in the same cycle):
  - Next cycle: cmd<=cmd_tmp, arg<=arg_tmp, cmd_valid<=1.
  - Latency is 1 clock from the CHK rx_valid to cmd_valid.
- Match, slot busy (cmd_valid=1 & cmd_ready=0): frame dropped; pulse err_overflow next cycle. cmd/arg/cmd_valid are unchanged.
- Handshake:
  - cmd/arg are stable while cmd_valid=1.
  - cmd_valid falls the cycle after cmd_valid & cmd_ready, unless a new good frame loads in that same cycle. In that case cmd_valid stays 1 with the new values.
  - cmd_ready while cmd_valid=0 is ignored.
- Timer:
  - Cleared on every accepted rx_valid and whenever state=S_SYNC.
  - Otherwise increments each cycle.
  - When timer reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: state<=S_SYNC, err_timeout pulses next cycle, partial frame discarded.
  - rx_valid in the same cycle as expiry: the byte wins, it is processed normally and the timer clears.
- Only one err_* pulse may occur per frame. Error pulses and cmd_valid assertion are mutually exclusive for a given frame.
- Async reset mid-frame or with a command pending discards everything immediately. There is no output glitch after release.
- rx_valid is assumed never to be asserted on consecutive cycles (UART rate). The design must still handle back-to-back strobes correctly, one byte per cycle.

Test Plan:
- Bytes A5,01,10,11 with cmd_ready=1 -> cmd_valid=1 one cycle after the 0x11 strobe, cmd=01, arg=10. Deasserts the cycle after acceptance. No err pulses.
- Bytes A5,02,03,FF -> err_chk pulse, chk_err_cnt 0->1, cmd_valid stays 0. Then A5,02,03,01 -> cmd=02, arg=03 delivered.
- Bytes 00,37,A5,04,05,01 (leading junk) -> junk ignored; cmd=04, arg=05 delivered, no errors.
- A5,06 then silence for TIMEOUT_CYCLES (use TIMEOUT_US=1, CLK_FREQ=10_000_000 -> 10 cycles) -> err_timeout pulse, state S_SYNC. Then A5,07,08,0F -> cmd=07 delivered. Also: a byte arriving exactly on the expiry cycle is accepted with no timeout.
- cmd_ready=0: frame A5,01,02,03 delivered, then frame A5,09,09,00 -> err_overflow pulse; cmd stays 01/02. Raise cmd_ready on the same cycle a third good frame completes -> cmd_valid remains 1 with the third frame's values.
- 256 bad-checksum frames -> chk_err_cnt=255 (saturated). Assert rst_n=0 mid-frame after A5,01 -> all outputs 0 immediately. After release, A5,01,10,11 -> correct delivery.
